// File: rtl/store_buffer.sv
// Word-granular store buffer between the memory stage and a single-port data memory.
// Optional STB_COALESCE_EN: a store matching the youngest entry overwrites it in place.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              empty,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_nonempty;
    logic              w_port_free;
    logic              w_drain;
    logic              w_coalesce;
    logic              w_accept;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PW-1:0]     w_idx;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_nonempty  = (r_count != '0);
    // The memory port belongs to a load whenever one is present; otherwise the head drains.
    assign w_port_free = ~cpu_re & w_nonempty;
    assign w_drain     = w_port_free & ~reset;

`ifdef STB_COALESCE_EN
    logic [PW-1:0] w_youngest;
    assign w_youngest = r_tail - PW'(1);
    // A lone entry that is draining this cycle cannot absorb the store.
    assign w_coalesce = cpu_we & w_nonempty
                      & (r_addr[w_youngest][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])
                      & ~((r_count == CW'(1)) & ~cpu_re);
`else
    assign w_coalesce = 1'b0;
`endif

    // A store enters the buffer without needing the memory port, so loads never block it.
    assign w_accept = cpu_we & ~w_full & ~w_coalesce;
    assign stall    = cpu_we & w_full & ~w_coalesce;

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    assign cpu_rdata = w_fwd_hit ? w_fwd_data : mem_rdata;
    assign mem_we    = w_drain;
    assign mem_addr  = w_port_free ? r_addr[r_head] : cpu_addr;
    assign mem_wdata = r_data[r_head];
    assign empty     = ~w_nonempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_drain);
        end
    end

    // Payload storage carries no reset; validity alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr[r_tail] <= cpu_addr;
            r_data[r_tail] <= cpu_wdata;
        end
`ifdef STB_COALESCE_EN
        if (w_coalesce) begin
            r_data[w_youngest] <= cpu_wdata;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model of the buffer contents.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic          empty;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // Model: queued stores, oldest at index 0.
    logic [AW-1:0] exp_q_addr[$];
    logic [DW-1:0] exp_q[$];

    logic          e_mem_we;
    logic          e_stall;
    logic          e_empty;
    logic [AW-1:0] e_mem_addr;
    logic [DW-1:0] e_mem_wdata;
    logic [DW-1:0] e_rdata;

    store_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .empty(empty), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit same_word(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:2] == b[AW-1:2];
    endfunction

    function automatic bit m_coalesce();
`ifdef STB_COALESCE_EN
        if (!cpu_we || exp_q_addr.size() == 0) return 1'b0;
        if (exp_q_addr.size() == 1 && !cpu_re) return 1'b0;
        return same_word(exp_q_addr[exp_q_addr.size()-1], cpu_addr);
`else
        return 1'b0;
`endif
    endfunction

    // Drive inputs, move to the falling edge and compute the expected outputs.
    task automatic drive(input logic rst, input logic we, input logic re,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] md);
        int n;
        reset = rst; cpu_we = we; cpu_re = re;
        cpu_addr = a; cpu_wdata = wd; mem_rdata = md;
        @(negedge clk);
        n           = exp_q_addr.size();
        e_empty     = (n == 0);
        e_mem_we    = !reset && !cpu_re && n > 0;
        e_mem_addr  = (!cpu_re && n > 0) ? exp_q_addr[0] : cpu_addr;
        e_mem_wdata = (n > 0) ? exp_q[0] : '0;
        e_stall     = cpu_we && n == DEPTH && !m_coalesce();
        e_rdata     = mem_rdata;
        for (int i = 0; i < n; i++) begin
            if (same_word(exp_q_addr[i], cpu_addr)) e_rdata = exp_q[i];
        end
    endtask

    // Clock edge: apply the buffer rules to the model.
    task automatic tick();
        bit co, acc, dr;
        @(posedge clk);
        if (reset) begin
            exp_q_addr.delete();
            exp_q.delete();
        end else begin
            co  = m_coalesce();
            acc = cpu_we && !co && exp_q_addr.size() < DEPTH;
            dr  = !cpu_re && exp_q_addr.size() > 0;
            if (co) exp_q[exp_q.size()-1] = cpu_wdata;
            if (dr) begin
                void'(exp_q_addr.pop_front());
                void'(exp_q.pop_front());
            end
            if (acc) begin
                exp_q_addr.push_back(cpu_addr);
                exp_q.push_back(cpu_wdata);
            end
        end
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 2 * DEPTH && exp_q_addr.size() > 0; i++) begin
            drive(0, 0, 0, '0, '0, '0);
            tick();
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        logic [DW-1:0] md;
        a = $urandom; md = $urandom;
        drive(1, 0, 0, a, '0, md);
        tick();
        drive(0, 0, 0, a, '0, md);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b want 1", empty); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== a) begin failures++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, a); end
        checks++; if (cpu_rdata !== md) begin failures++; $display("FAIL reset_rdata: got %h want %h", cpu_rdata, md); end
        tick();
    endtask

    task automatic test_single_store();
        drive(0, 1, 0, 32'h100, 32'hDEADBEEF, '0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL single_stall: got %0b want 0", stall); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_we0: got %0b want 0", mem_we); end
        tick();
        drive(0, 0, 0, '0, '0, '0);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty0: got %0b want 0", empty); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL single_we1: got %0b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL single_addr: got %h want 100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wdata: got %h want deadbeef", mem_wdata); end
        tick();
        drive(0, 0, 0, '0, '0, '0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty1: got %0b want 1", empty); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL single_idle_we: got %0b want 0", mem_we); end
        tick();
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 1, AW'(i * 4), DW'(32'hA0 + i), '0);
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fill_stall_%0d: got %0b want 0", i, stall); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fill_we_%0d: got %0b want 0", i, mem_we); end
            tick();
        end
        drive(0, 1, 0, 32'h10, 32'hB0, '0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall: got %0b want 1", stall); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL full_drain_we: got %0b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL full_drain_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'hA0) begin failures++; $display("FAIL full_drain_data: got %h want a0", mem_wdata); end
        tick();
        drive(0, 1, 0, 32'h10, 32'hB0, '0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL held_stall: got %0b want 0", stall); end
        checks++; if (mem_addr !== 32'h4) begin failures++; $display("FAIL held_drain_addr: got %h want 4", mem_addr); end
        tick();
        drive(0, 0, 1, 32'h10, '0, 32'h77);
        checks++; if (cpu_rdata !== 32'hB0) begin failures++; $display("FAIL held_visible: got %h want b0", cpu_rdata); end
        tick();
        flush();
    endtask

    task automatic test_forward();
        drive(0, 1, 1, 32'h20, 32'h11, '0); tick();
        drive(0, 1, 1, 32'h20, 32'h22, '0); tick();
        drive(0, 0, 1, 32'h20, '0, 32'h99);
        checks++; if (cpu_rdata !== 32'h22) begin failures++; $display("FAIL fwd_youngest: got %h want 22", cpu_rdata); end
        tick();
        drive(0, 0, 1, 32'h24, '0, 32'h99);
        checks++; if (cpu_rdata !== 32'h99) begin failures++; $display("FAIL fwd_miss: got %h want 99", cpu_rdata); end
        tick();
        drive(0, 0, 1, 32'h23, '0, 32'h99);
        checks++; if (cpu_rdata !== 32'h22) begin failures++; $display("FAIL fwd_lowbits: got %h want 22", cpu_rdata); end
        checks++; if (mem_addr !== 32'h23) begin failures++; $display("FAIL fwd_mem_addr: got %h want 23", mem_addr); end
        tick();
        flush();
    endtask

    task automatic test_load_hold();
        logic [DW-1:0] d[3];
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            drive(0, 1, 1, AW'(32'h40 + i * 4), d[i], '0); tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 32'h200, '0, $urandom);
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL hold_we_%0d: got %0b want 0", i, mem_we); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, '0, '0);
            checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL hold_drain_we_%0d: got %0b want 1", i, mem_we); end
            checks++; if (mem_addr !== AW'(32'h40 + i * 4)) begin failures++; $display("FAIL hold_drain_addr_%0d: got %h want %h", i, mem_addr, 32'h40 + i * 4); end
            checks++; if (mem_wdata !== d[i]) begin failures++; $display("FAIL hold_drain_data_%0d: got %h want %h", i, mem_wdata, d[i]); end
            tick();
        end
        drive(0, 0, 0, '0, '0, '0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL hold_empty: got %0b want 1", empty); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] md;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, AW'(32'h60 + i * 4), $urandom, '0); tick();
        end
        drive(1, 0, 0, '0, '0, '0);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_we: got %0b want 0", mem_we); end
        tick();
        md = $urandom;
        drive(0, 0, 1, 32'h64, '0, md);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty: got %0b want 1", empty); end
        checks++; if (cpu_rdata !== md) begin failures++; $display("FAIL rstmid_rdata: got %h want %h", cpu_rdata, md); end
        tick();
    endtask

    task automatic test_full_same_addr();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 1, AW'(32'h24 + i * 4), DW'(32'hD0 + i), '0); tick();
        end
        drive(0, 1, 1, 32'h30, 32'h55, '0);
`ifdef STB_COALESCE_EN
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL coal_stall: got %0b want 0", stall); end
`else
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL coal_stall: got %0b want 1", stall); end
`endif
        tick();
        drive(0, 0, 1, 32'h30, '0, 32'h99);
`ifdef STB_COALESCE_EN
        checks++; if (cpu_rdata !== 32'h55) begin failures++; $display("FAIL coal_rdata: got %h want 55", cpu_rdata); end
`else
        checks++; if (cpu_rdata !== 32'hD3) begin failures++; $display("FAIL coal_rdata: got %h want d3", cpu_rdata); end
`endif
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL coal_empty: got %0b want 0", empty); end
        tick();
        flush();
    endtask

    task automatic test_random();
        logic          we, re, rst;
        logic [AW-1:0] a;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            we  = $urandom_range(0, 1);
            re  = ($urandom_range(0, 2) == 0);
            a   = 32'h80 + AW'($urandom_range(0, 7) * 4) + AW'($urandom_range(0, 3));
            drive(rst, we, re, a, $urandom, $urandom);
            checks++; if (mem_we !== e_mem_we) begin failures++; $display("FAIL rnd_mem_we c%0d: got %0b want %0b", c, mem_we, e_mem_we); end
            checks++; if (stall !== e_stall) begin failures++; $display("FAIL rnd_stall c%0d: got %0b want %0b", c, stall, e_stall); end
            checks++; if (empty !== e_empty) begin failures++; $display("FAIL rnd_empty c%0d: got %0b want %0b", c, empty, e_empty); end
            checks++; if (mem_addr !== e_mem_addr) begin failures++; $display("FAIL rnd_mem_addr c%0d: got %h want %h", c, mem_addr, e_mem_addr); end
            checks++; if (cpu_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, cpu_rdata, e_rdata); end
            if (e_mem_we) begin
                checks++; if (mem_wdata !== e_mem_wdata) begin failures++; $display("FAIL rnd_mem_wdata c%0d: got %h want %h", c, mem_wdata, e_mem_wdata); end
            end
            tick();
        end
        flush();
    endtask

    initial begin
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        test_reset();
        test_single_store();
        test_fill_stall();
        test_forward();
        test_load_hold();
        test_reset_mid();
        test_full_same_addr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
